// File: rtl/corner_pkg.sv
// corner_pkg: coordinate width, corner indices, FSM states and screen limits shared by the corner filter
package corner_pkg;
    localparam int COORD_W  = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam logic [2:0] TL_X = 3'd0, TL_Y = 3'd1, TR_X = 3'd2, TR_Y = 3'd3,
                           BL_X = 3'd4, BL_Y = 3'd5, BR_X = 3'd6, BR_Y = 3'd7;
    typedef enum logic [2:0] {IDLE, CAPTURE, CHECK, FILTER, CENTROID, PUBLISH} state_t;
endpackage

// File: rtl/corner_track_filter_ema_step.sv
// ema_step: one EMA update filt + ((new - filt) >>> ALPHA_SHIFT), or a straight load on the first frame
module ema_step
    import corner_pkg::*;
#(
    parameter int ALPHA_SHIFT = 2
) (
    input  logic [COORD_W-1:0] new_val,
    input  logic [COORD_W-1:0] filt_val,
    input  logic               first,
    output logic [COORD_W-1:0] next_val
);
    logic signed [COORD_W:0] d;
    assign d = $signed({1'b0, new_val}) - $signed({1'b0, filt_val});
    // the step never leaves [filt, new], so modular 10-bit arithmetic is exact
    assign next_val = first ? new_val : filt_val + COORD_W'(d >>> ALPHA_SHIFT);
endmodule

// File: rtl/corner_track_filter.sv
// corner_track_filter: per-frame corner capture, quad check, time-shared EMA and centroid with valid/ready publish; CORNER_FILTER_LOST_EN adds track-loss detection
module corner_track_filter
    import corner_pkg::*;
#(
    parameter int ALPHA_SHIFT = 2,
    parameter int MIN_SIZE    = 4
`ifdef CORNER_FILTER_LOST_EN
    ,
    parameter int LOST_FRAMES = 8
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       VGA_VS,
    input  logic [9:0] tl_x,
    input  logic [9:0] tl_y,
    input  logic [9:0] tr_x,
    input  logic [9:0] tr_y,
    input  logic [9:0] bl_x,
    input  logic [9:0] bl_y,
    input  logic [9:0] br_x,
    input  logic [9:0] br_y,
    output logic [9:0] filt_tl_x,
    output logic [9:0] filt_tl_y,
    output logic [9:0] filt_tr_x,
    output logic [9:0] filt_tr_y,
    output logic [9:0] filt_bl_x,
    output logic [9:0] filt_bl_y,
    output logic [9:0] filt_br_x,
    output logic [9:0] filt_br_y,
    output logic [9:0] cent_x,
    output logic [9:0] cent_y,
    output logic       track_valid,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overrun,
    output logic       lost
);
    state_t state;
    logic vs_prev, first_frame, frame_ok, trk, quad_ok;
    logic [2:0] idx;
    logic [7:0][COORD_W-1:0] in_c, cap, filt;
    logic [COORD_W-1:0] ema_out, cent_x_r, cent_y_r;
    logic [11:0] sum_x, sum_y;

    assign in_c = {br_y, br_x, bl_y, bl_x, tr_y, tr_x, tl_y, tl_x};
    assign quad_ok = (11'(cap[BR_X]) >= 11'(cap[TL_X]) + 11'(MIN_SIZE)) &&
                     (11'(cap[BL_Y]) >= 11'(cap[TR_Y]) + 11'(MIN_SIZE)) && (|cap);
    assign sum_x = 12'(filt[TL_X]) + 12'(filt[TR_X]) + 12'(filt[BL_X]) + 12'(filt[BR_X]);
    assign sum_y = 12'(filt[TL_Y]) + 12'(filt[TR_Y]) + 12'(filt[BL_Y]) + 12'(filt[BR_Y]);

    ema_step #(.ALPHA_SHIFT(ALPHA_SHIFT)) u_ema (
        .new_val (cap[idx]),
        .filt_val(filt[idx]),
        .first   (first_frame),
        .next_val(ema_out)
    );

`ifdef CORNER_FILTER_LOST_EN
    logic [3:0] miss, miss_nxt;
    logic lost_r;
    assign miss_nxt = miss + {3'b0, ~&miss};
`else
    assign lost = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            vs_prev     <= 1'b0;
            first_frame <= 1'b1;
            frame_ok    <= 1'b0;
            trk         <= 1'b0;
            idx         <= '0;
            cap         <= '0;
            filt        <= '0;
            cent_x_r    <= '0;
            cent_y_r    <= '0;
            filt_tl_x   <= '0;
            filt_tl_y   <= '0;
            filt_tr_x   <= '0;
            filt_tr_y   <= '0;
            filt_bl_x   <= '0;
            filt_bl_y   <= '0;
            filt_br_x   <= '0;
            filt_br_y   <= '0;
            cent_x      <= '0;
            cent_y      <= '0;
            track_valid <= 1'b0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
`ifdef CORNER_FILTER_LOST_EN
            miss        <= '0;
            lost_r      <= 1'b0;
            lost        <= 1'b0;
`endif
        end else begin
            vs_prev <= VGA_VS;
            overrun <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                IDLE: if (vs_prev && !VGA_VS) state <= CAPTURE;
                CAPTURE: begin
                    cap   <= in_c;
                    state <= CHECK;
                end
                CHECK: begin
                    idx      <= '0;
                    frame_ok <= quad_ok;
                    state    <= quad_ok ? FILTER : CENTROID;
`ifdef CORNER_FILTER_LOST_EN
                    miss <= quad_ok ? 4'd0 : miss_nxt;
                    if (quad_ok) lost_r <= 1'b0;
                    else if (miss_nxt >= 4'(LOST_FRAMES)) begin
                        lost_r      <= 1'b1;
                        first_frame <= 1'b1;
                    end
`endif
                end
                FILTER: begin
                    filt[idx] <= ema_out;
                    idx       <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        first_frame <= 1'b0;
                        state       <= CENTROID;
                    end
                end
                CENTROID: begin
                    trk <= frame_ok;
                    if (frame_ok) begin
                        cent_x_r <= COORD_W'(sum_x >> 2);
                        cent_y_r <= COORD_W'(sum_y >> 2);
                    end
                    state <= PUBLISH;
                end
                PUBLISH: begin
                    // an unaccepted result stays put; the newer one is dropped
                    if (out_valid && !out_ready) overrun <= 1'b1;
                    else begin
                        out_valid   <= 1'b1;
                        filt_tl_x   <= filt[TL_X];
                        filt_tl_y   <= filt[TL_Y];
                        filt_tr_x   <= filt[TR_X];
                        filt_tr_y   <= filt[TR_Y];
                        filt_bl_x   <= filt[BL_X];
                        filt_bl_y   <= filt[BL_Y];
                        filt_br_x   <= filt[BR_X];
                        filt_br_y   <= filt[BR_Y];
                        cent_x      <= cent_x_r;
                        cent_y      <= cent_y_r;
                        track_valid <= trk;
`ifdef CORNER_FILTER_LOST_EN
                        lost        <= lost_r;
`endif
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_corner_track_filter.sv
// tb_corner_track_filter: randomized scoreboard bench for corner_track_filter against a frame-level reference model
module tb_corner_track_filter;
    import corner_pkg::*;
    localparam int ALPHA = 2, MINS = 4, LOSTF = 8;
    typedef logic [7:0][9:0] quad_t;
    typedef struct packed { quad_t f; logic [9:0] cx, cy; logic trk, lost; } res_t;
    typedef struct packed { res_t r; logic drop; } item_t;

    logic clk = 0, reset = 1, VGA_VS = 1, out_ready = 1;
    quad_t cin = '0, fo;
    logic [9:0] cent_x, cent_y;
    logic track_valid, out_valid, overrun, lost;
    res_t act;
    item_t q[$];
    int checks = 0, errors = 0;
    int mf[8], mcx, mcy, mmiss;
    bit mtrk, mfirst, mlost;

    corner_track_filter dut (
        .clk(clk), .reset(reset), .VGA_VS(VGA_VS),
        .tl_x(cin[0]), .tl_y(cin[1]), .tr_x(cin[2]), .tr_y(cin[3]),
        .bl_x(cin[4]), .bl_y(cin[5]), .br_x(cin[6]), .br_y(cin[7]),
        .filt_tl_x(fo[0]), .filt_tl_y(fo[1]), .filt_tr_x(fo[2]), .filt_tr_y(fo[3]),
        .filt_bl_x(fo[4]), .filt_bl_y(fo[5]), .filt_br_x(fo[6]), .filt_br_y(fo[7]),
        .cent_x(cent_x), .cent_y(cent_y), .track_valid(track_valid),
        .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun), .lost(lost)
    );

    always #5 clk = ~clk;
    assign act = {fo, cent_x, cent_y, track_valid, lost};

    function automatic quad_t quad(int a, int b, int c, int d, int e, int f, int g, int h);
        return {10'(h), 10'(g), 10'(f), 10'(e), 10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    function automatic int fdiv(int a, int b);
        return a >= 0 ? a / b : -((-a + b - 1) / b);
    endfunction

    task automatic model_reset();
        foreach (mf[i]) mf[i] = 0;
        mcx = 0; mcy = 0; mmiss = 0; mtrk = 0; mfirst = 1; mlost = 0;
    endtask

    // Frame-level behaviour: validity, EMA toward the new corners, mean of the four corners
    task automatic model_frame(input quad_t c, output res_t r);
        int w = int'(c[6]) - int'(c[0]);
        int h = int'(c[5]) - int'(c[3]);
        if (w >= MINS && h >= MINS && c != '0) begin
            for (int i = 0; i < 8; i++)
                mf[i] = mfirst ? int'(c[i]) : mf[i] + fdiv(int'(c[i]) - mf[i], 1 << ALPHA);
            mfirst = 0;
            mcx = (mf[0] + mf[2] + mf[4] + mf[6]) / 4;
            mcy = (mf[1] + mf[3] + mf[5] + mf[7]) / 4;
            mtrk = 1; mmiss = 0; mlost = 0;
        end else begin
            mtrk = 0;
            mmiss = mmiss < 15 ? mmiss + 1 : 15;
`ifdef CORNER_FILTER_LOST_EN
            if (mmiss >= LOSTF) begin mlost = 1; mfirst = 1; end
`endif
        end
        for (int i = 0; i < 8; i++) r.f[i] = 10'(mf[i]);
        r.cx = 10'(mcx); r.cy = 10'(mcy); r.trk = mtrk; r.lost = mlost;
    endtask

    task automatic issue(input quad_t c, input bit drop, input bit commit);
        item_t it;
        @(posedge clk); #1;
        cin = c;
        if (commit) begin
            model_frame(c, it.r);
            it.drop = drop;
            q.push_back(it);
        end
        VGA_VS = 0;
    endtask

    task automatic tail(input int n, input bit rnd);
        repeat (3) @(posedge clk);
        #1 VGA_VS = 1;
        repeat (n) begin
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1;
        while ((out_valid || q.size() != 0) && n < 40) begin @(posedge clk); #1; n++; end
        checks++;
        if (out_valid || q.size() != 0) begin
            errors++;
            $display("FAIL drain: out_valid=%0b pending=%0d, required 0 and 0", out_valid, q.size());
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({act, out_valid, overrun} != '0) begin
            errors++;
            $display("FAIL %s: outputs=%h valid=%0b overrun=%0b, required all 0", name, act, out_valid, overrun);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0b, required %0b", name, got, want);
        end
    endtask

    always @(negedge clk) if (!reset) begin
        if (overrun) begin
            int k;
            k = -1;
            foreach (q[i]) if (k < 0 && q[i].drop) k = i;
            checks++;
            if (k < 0) begin
                errors++;
                $display("FAIL overrun: got pulse, required none (no dropped result expected)");
            end else q.delete(k);
        end
        if (out_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL spurious_valid: got out_valid=1 with %h, required no result", act);
            end else begin
                if (act !== q[0].r) begin
                    errors++;
                    $display("FAIL result: got %h, required %h", act, q[0].r);
                end
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        quad_t c;
        model_reset();
        repeat (3) @(posedge clk); #1;
        check_zero("reset");
        reset = 0;
        c = quad(100, 200, 150, 100, 140, 300, 200, 210);
        issue(c, 0, 1); tail(14, 0); drain();
        c = quad(140, 200, 190, 100, 180, 300, 240, 210);
        issue(c, 0, 1); tail(14, 0); drain();
        issue('0, 0, 1); tail(14, 0); drain();
        issue(quad(50, 60, 80, 40, 50, 44, 54, 90), 0, 1); tail(14, 0); drain();
        issue(quad(50, 60, 80, 40, 50, 44, 53, 90), 0, 1); tail(14, 0); drain();
        issue(quad(50, 60, 80, 40, 50, 43, 54, 90), 0, 1); tail(14, 0); drain();
        // held result across two frames: second is dropped with one overrun pulse
        out_ready = 0;
        issue(quad(300, 300, 400, 250, 310, 420, 420, 410), 0, 1); tail(14, 0);
        issue(quad(320, 310, 410, 260, 300, 430, 440, 400), 1, 1); tail(14, 0);
        check_bit("held_valid", out_valid, 1'b1);
        out_ready = 1;
        @(posedge clk); #1;
        check_bit("valid_drop", out_valid, 1'b0);
        drain();
        // ready arrives in the same cycle the next result is published
        out_ready = 0;
        issue(quad(200, 100, 260, 90, 210, 200, 270, 190), 0, 1); tail(14, 0);
        issue(quad(220, 120, 280, 80, 200, 220, 290, 180), 0, 1);
        repeat (3) @(posedge clk);
        #1 VGA_VS = 1;
        repeat (9) @(posedge clk);
        #1 out_ready = 1;
        repeat (6) @(posedge clk); #1;
        drain();
        // reset mid-filter discards the frame and restarts unfiltered
        issue(quad(10, 10, 90, 5, 20, 99, 95, 88), 0, 0);
        repeat (3) @(posedge clk);
        #1 VGA_VS = 1;
        repeat (3) @(posedge clk);
        #1 reset = 1;
        #1 check_zero("mid_reset");
        model_reset();
        q.delete();
        @(posedge clk); #1 reset = 0;
        issue(quad(400, 300, 500, 280, 410, 400, 520, 390), 0, 1); tail(14, 0); drain();
        issue(quad(360, 320, 460, 300, 380, 420, 480, 410), 0, 1); tail(14, 0); drain();
        for (int i = 0; i < LOSTF; i++) begin issue('0, 0, 1); tail(14, 0); drain(); end
        issue(quad(300, 200, 380, 180, 310, 290, 390, 280), 0, 1); tail(14, 0); drain();
        for (int n = 0; n < 24; n++) begin
            int tx = $urandom_range(0, SCREEN_W - 240), ty = $urandom_range(0, SCREEN_H - 180);
            if ($urandom_range(0, 9) == 0) c = '0;
            else c = quad(tx, $urandom_range(0, SCREEN_H - 1), $urandom_range(0, SCREEN_W - 1), ty,
                          $urandom_range(0, SCREEN_W - 1), ty + $urandom_range(3, 170),
                          tx + $urandom_range(3, 200), $urandom_range(0, SCREEN_H - 1));
            issue(c, 0, 1); tail(14, 1); drain();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
